// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the canonical NOP encoding and the
// fetch FSM state type.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer that parks an
// instruction returned while decode is stalled.
module ifid_reg #(
    parameter int unsigned XLEN = core_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            deliver_valid_i,
    input  logic [XLEN-1:0] deliver_pc_i,
    input  logic [31:0]     deliver_instr_i,
    output logic            hold_full_o,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic [31:0]     ifid_instr_o
);
    import core_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;

    // Next-state selection: flush beats stall, a parked entry beats new delivery.
    always_comb begin
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        hold_valid_d    = hold_valid_q;
        hold_pc_d       = hold_pc_q;
        hold_instr_d    = hold_instr_q;
        if (flush_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
            hold_valid_d = 1'b0;
        end else if (stall_i) begin
            if (deliver_valid_i) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = deliver_pc_i;
                hold_instr_d = deliver_instr_i;
            end else begin
                hold_valid_d = hold_valid_q;
            end
        end else if (hold_valid_q) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = hold_pc_q;
            ifid_pc_plus4_d = hold_pc_q + PC_STEP;
            ifid_instr_d    = hold_instr_q;
            hold_valid_d    = 1'b0;
        end else if (deliver_valid_i) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = deliver_pc_i;
            ifid_pc_plus4_d = deliver_pc_i + PC_STEP;
            ifid_instr_d    = deliver_instr_i;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
        end
    end

    // IF/ID and hold buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= NOP;
            hold_valid_q    <= 1'b0;
            hold_pc_q       <= '0;
            hold_instr_q    <= NOP;
        end else begin
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            hold_valid_q    <= hold_valid_d;
            hold_pc_q       <= hold_pc_d;
            hold_instr_q    <= hold_instr_d;
        end
    end

    assign hold_full_o     = hold_valid_q;
    assign ifid_valid_o    = ifid_valid_q;
    assign ifid_pc_o       = ifid_pc_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_instr_o    = ifid_instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC register and a single-outstanding-request FSM
// talking to instruction memory, feeding the IF/ID register.
module fetch_stage #(
    parameter int unsigned          XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr
);
    import core_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] redirect_target_s;
    logic            req_valid_s;
    logic            deliver_valid_s;
    logic            hold_full_s;

    assign redirect_target_s = redirect_pc & ALIGN_MASK;

    // FSM next state, PC update and request/delivery strobes.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        inflight_pc_d   = inflight_pc_q;
        req_valid_s     = 1'b0;
        deliver_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (redirect_valid) begin
                    pc_d = redirect_target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_target_s;
                end else begin
                    req_valid_s = !hold_full_s;
                    if (!hold_full_s && imem_req_ready) begin
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + PC_STEP;
                        state_d       = WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // The in-flight instruction is on the wrong path.
                    pc_d    = redirect_target_s;
                    state_d = imem_rsp_valid ? RUN : KILL;
                end else if (imem_rsp_valid) begin
                    deliver_valid_s = 1'b1;
                    state_d         = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            KILL: begin
                if (redirect_valid) begin
                    pc_d = redirect_target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rsp_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = KILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_q;

    ifid_reg #(
        .XLEN (XLEN)
    ) u_ifid_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i | redirect_valid),
        .deliver_valid_i (deliver_valid_s),
        .deliver_pc_i    (inflight_pc_q),
        .deliver_instr_i (imem_rsp_data),
        .hold_full_o     (hold_full_s),
        .ifid_valid_o    (ifid_valid),
        .ifid_pc_o       (ifid_pc),
        .ifid_pc_plus4_o (ifid_pc_plus4),
        .ifid_instr_o    (ifid_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected requests and IF/ID loads are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
    } ifid_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;

    logic [31:0] req_q[$];
    ifid_t       exp_q[$];
    bit          auto_rsp;
    int          total;
    int          bad;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_instr     (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; the memory answers an accepted request on the next cycle
    // with {16'hC0DE, addr[15:0]} when auto_rsp is set.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp && acc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hC0DE, a[15:0]};
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0000_0000;
        end
    endtask

    task automatic push_ifid(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins);
        ifid_t e;
        e.pc  = pc;
        e.pc4 = pc4;
        e.ins = ins;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        auto_rsp       = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic end_test(input string name);
        chk({name, "_req_left"}, 32'(req_q.size()), 32'd0);
        chk({name, "_ifid_left"}, 32'(exp_q.size()), 32'd0);
        req_q.delete();
        exp_q.delete();
    endtask

    // Scoreboard monitor: request handshakes and IF/ID register contents.
    initial begin
        logic        prv_stall;
        logic        prv_kill;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        logic [31:0] a;
        ifid_t       e;
        prv_stall = 1'b0;
        prv_kill  = 1'b0;
        exp_v     = 1'b0;
        exp_pc    = 32'h0000_0000;
        exp_in    = NOP_W;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prv_stall = 1'b0;
                prv_kill  = 1'b0;
                exp_v     = 1'b0;
                exp_in    = NOP_W;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    if (req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_extra: got request at %h expected none (t=%0t)", imem_addr, $time);
                    end else begin
                        a = req_q.pop_front();
                        chk("req_addr", imem_addr, a);
                    end
                end
                if (prv_kill) begin
                    chk("flush_valid", 32'(ifid_valid), 32'd0);
                    chk("flush_instr", ifid_instr, NOP_W);
                    exp_v  = 1'b0;
                    exp_in = NOP_W;
                end else if (prv_stall) begin
                    chk("stall_valid", 32'(ifid_valid), 32'(exp_v));
                    chk("stall_instr", ifid_instr, exp_in);
                    if (exp_v) begin
                        chk("stall_pc", ifid_pc, exp_pc);
                    end
                end else if (ifid_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ifid_extra: got pc %h instr %h expected bubble (t=%0t)", ifid_pc, ifid_instr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ifid_pc", ifid_pc, e.pc);
                        chk("ifid_pc4", ifid_pc_plus4, e.pc4);
                        chk("ifid_instr", ifid_instr, e.ins);
                        exp_v  = 1'b1;
                        exp_pc = e.pc;
                        exp_in = e.ins;
                    end
                end else begin
                    chk("bubble_instr", ifid_instr, NOP_W);
                    exp_v  = 1'b0;
                    exp_in = NOP_W;
                end
                prv_stall = stall_i;
                prv_kill  = flush_i | redirect_valid;
            end
        end
    end

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        auto_rsp       = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'h0000_0000);
        chk("rst_ifid_pc4", ifid_pc_plus4, 32'h0000_0000);
        chk("rst_ifid_instr", ifid_instr, NOP_W);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        rst_n = 1'b1;

        // Straight-line fetch with a 1-cycle memory.
        req_q.push_back(32'h0000_0000);
        req_q.push_back(32'h0000_0004);
        req_q.push_back(32'h0000_0008);
        push_ifid(32'h0000_0000, 32'h0000_0004, 32'hC0DE_0000);
        push_ifid(32'h0000_0004, 32'h0000_0008, 32'hC0DE_0004);
        push_ifid(32'h0000_0008, 32'h0000_000C, 32'hC0DE_0008);
        repeat (6) step();
        imem_req_ready = 1'b0;
        repeat (4) step();
        end_test("seq");

        // Redirect while waiting, response arrives later and is dropped.
        do_reset();
        auto_rsp = 1'b0;
        req_q.push_back(32'h0000_0000);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000;
        #1;
        chk("kill_no_req", 32'(imem_req_valid), 32'd0);
        req_q.push_back(32'h0000_0100);
        auto_rsp = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        push_ifid(32'h0000_0100, 32'h0000_0104, 32'hC0DE_0100);
        repeat (3) step();
        end_test("kill");

        // Response during a 3-cycle stall is parked, then released.
        do_reset();
        req_q.push_back(32'h0000_0000);
        step();
        step();
        imem_rsp_data = 32'hDEAD_BEEF;
        stall_i       = 1'b1;
        step();
        #1;
        chk("stall_no_req1", 32'(imem_req_valid), 32'd0);
        step();
        #1;
        chk("stall_no_req2", 32'(imem_req_valid), 32'd0);
        step();
        stall_i = 1'b0;
        #1;
        chk("stall_no_req3", 32'(imem_req_valid), 32'd0);
        req_q.push_back(32'h0000_0004);
        push_ifid(32'h0000_0000, 32'h0000_0004, 32'hDEAD_BEEF);
        step();
        step();
        imem_req_ready = 1'b0;
        push_ifid(32'h0000_0004, 32'h0000_0008, 32'hC0DE_0004);
        repeat (3) step();
        end_test("stall");

        // Flush with stall clears a full hold buffer.
        do_reset();
        req_q.push_back(32'h0000_0000);
        step();
        step();
        stall_i = 1'b1;
        step();
        flush_i = 1'b1;
        step();
        stall_i = 1'b0;
        flush_i = 1'b0;
        req_q.push_back(32'h0000_0004);
        #1;
        chk("flush_stall_valid", 32'(ifid_valid), 32'd0);
        chk("flush_stall_instr", ifid_instr, NOP_W);
        step();
        imem_req_ready = 1'b0;
        push_ifid(32'h0000_0004, 32'h0000_0008, 32'hC0DE_0004);
        repeat (3) step();
        end_test("flush");

        // PC wrap and redirect target alignment.
        do_reset();
        req_q.push_back(32'hFFFF_FFFC);
        req_q.push_back(32'h0000_0000);
        req_q.push_back(32'h0000_0100);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        step();
        push_ifid(32'hFFFF_FFFC, 32'h0000_0000, 32'hC0DE_FFFC);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        step();
        imem_req_ready = 1'b0;
        push_ifid(32'h0000_0100, 32'h0000_0104, 32'hC0DE_0100);
        repeat (3) step();
        end_test("wrap");

        // Reset in the middle of a wait, then a stale response.
        do_reset();
        auto_rsp = 1'b0;
        req_q.push_back(32'h0000_0000);
        step();
        step();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0000_0000);
        chk("mid_rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("mid_rst_ifid_pc4", ifid_pc_plus4, 32'h0000_0000);
        chk("mid_rst_ifid_instr", ifid_instr, NOP_W);
        step();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        req_q.push_back(32'h0000_0000);
        step();
        auto_rsp = 1'b1;
        step();
        imem_req_ready = 1'b0;
        push_ifid(32'h0000_0000, 32'h0000_0004, 32'hC0DE_0000);
        repeat (3) step();
        end_test("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port imem_req_valid, output, 1, fetch request to insmemory.
REQ-007 SHALL have port imem_req_ready, input, 1, insmemory accepts request.
REQ-008 SHALL have port imem_addr, output, XLEN, request address, word-aligned.
REQ-009 SHALL have port imem_rsp_valid, input, 1, instruction returned.
REQ-010 SHALL have port imem_rsp_data, input, 32, returned instruction.
REQ-011 SHALL have port stall_i, input, 1, hold IF/ID (from hazard_detection).
REQ-012 SHALL have port flush_i, input, 1, squash IF/ID to bubble.
REQ-013 SHALL have port redirect_valid, input, 1, branch/jump taken from exeunit.
REQ-014 SHALL have port redirect_pc, input, XLEN, redirect target.
REQ-015 SHALL have ports ifid_valid (1), ifid_pc (XLEN), ifid_pc_plus4 (XLEN) and ifid_instr (32), all outputs, forming the IF/ID register feeding control/immmaker/registers.

Function
REQ-016 SHALL hold next-fetch PC register pc; imem_addr = pc while imem_req_valid=1.
REQ-017 SHALL allow at most one outstanding request; the FSM SHALL have states IDLE, RUN, WAIT and KILL.
REQ-018 In IDLE, SHALL drive imem_req_valid=0 and move to RUN next cycle.
REQ-019 In RUN, SHALL assert imem_req_valid when hold buffer empty; on valid&ready: inflight_pc<=pc, pc<=pc+4, and go to WAIT.
REQ-020 In WAIT, on imem_rsp_valid without redirect, SHALL deliver {inflight_pc, data} and go to RUN.
REQ-021 On redirect_valid in RUN, SHALL load pc<=redirect_pc and suppress request acceptance that cycle (imem_req_valid=0), staying in RUN.
REQ-022 On redirect_valid in WAIT, SHALL load pc<=redirect_pc; a same-cycle response SHALL be discarded and the FSM go to RUN, otherwise it SHALL go to KILL.
REQ-023 In KILL, SHALL discard the next response and go to RUN; a further redirect SHALL update pc and stay in KILL.
REQ-024 redirect_pc[1:0] SHALL be ignored (forced 2'b00).
REQ-025 pc+4 SHALL wrap modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 A delivered response with stall_i=0 SHALL load IF/ID next edge: ifid_valid=1, ifid_pc, ifid_pc_plus4=ifid_pc+4, ifid_instr.
REQ-027 A delivered response with stall_i=1 SHALL be captured in a one-entry hold buffer; no new request SHALL be issued while it is full.
REQ-028 When stall_i falls, the hold buffer SHALL load IF/ID next edge and empty.
REQ-029 stall_i=1 without flush SHALL keep all IF/ID outputs unchanged.
REQ-030 flush_i=1 or redirect_valid=1 SHALL set ifid_valid=0, ifid_instr=NOP, and empty the hold buffer; flush SHALL take priority over stall.
REQ-031 No delivery and no stall SHALL load a bubble (ifid_valid=0, ifid_instr=NOP).
REQ-032 Fetch-to-IF/ID latency SHALL be 1 cycle after imem_rsp_valid; steady-state throughput with 1-cycle memory SHALL be 1 instruction per 2 cycles.

Reset
REQ-033 While rst_n=0: pc=RESET_PC, state=IDLE, hold buffer empty, imem_req_valid=0, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP.
REQ-034 Reset mid-WAIT SHALL abandon the outstanding request; a response in the first cycle after reset SHALL be ignored (IDLE).

Structure
REQ-035 XLEN, NOP (32'h0000_0013) and the FSM state enum SHALL live in shared package core_pkg.
REQ-036 The IF/ID register plus hold buffer SHALL be one sub-module, ifid_reg; PC/FSM logic SHALL stay in fetch_stage.

Verification
REQ-037 Reset release, ready=1, 1-cycle memory -> requests at 0x0, 0x4, 0x8; IF/ID shows pc 0x0 then 0x4 with correct instr.
REQ-038 Redirect to 0x100 in WAIT with no response -> KILL; next response dropped (ifid_valid=0); next request addr 0x100.
REQ-039 stall_i=1 for 3 cycles while response 0xDEADBEEF arrives -> IF/ID unchanged, no request issued; IF/ID=0xDEADBEEF one cycle after stall drops.
REQ-040 flush_i=1 and stall_i=1 together -> ifid_valid=0, ifid_instr=0x00000013, hold buffer cleared.
REQ-041 pc=0xFFFF_FFFC accepted -> next imem_addr 0x0; redirect_pc=0x103 -> imem_addr 0x100.
REQ-042 rst_n asserted during WAIT, late response arrives -> outputs at reset values, first post-reset request addr RESET_PC.
